// File: rtl/operand_fetch_pkg.sv
// Shared constants and types for the operand fetch stage.
//   ADDR_W   - register address width
//   NUM_REGS - number of architectural registers
//   WORD_W   - data word width
package operand_fetch_pkg;

    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int WORD_W   = 32;

    // Contents of the single output stage handed to execute.
    typedef struct packed {
        logic [WORD_W-1:0] op1;
        logic [WORD_W-1:0] op2;
        logic [ADDR_W-1:0] rd;
        logic              rd_we;
    } out_stage_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] vec;
        vec       = '0;
        vec[addr] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/operand_fetch_sb.sv
// Pending-writer scoreboard for the register file.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   set_en_i/set_addr_i   - mark a register as having an in-flight writer
//   fclr_en_i/fclr_addr_i - drop a squashed writer's pending bit
//   clr_en_i/clr_addr_i   - writeback retiring a register
//   look_a/b/c_i          - lookup addresses
//   pend_a/b/c_o          - effective pending bits (pending and not retiring this cycle)
module rf_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              fclr_en_i,
    input  logic [ADDR_W-1:0] fclr_addr_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] look_a_i,
    input  logic [ADDR_W-1:0] look_b_i,
    input  logic [ADDR_W-1:0] look_c_i,
    output logic              pend_a_o,
    output logic              pend_b_o,
    output logic              pend_c_o
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic [NUM_REGS-1:0] eff_pend;

    // A writeback in this cycle already resolves the hazard, so lookups see it cleared.
    assign eff_pend = pend_q & ~(clr_en_i ? reg_onehot(clr_addr_i) : '0);

    assign pend_a_o = eff_pend[look_a_i];
    assign pend_b_o = eff_pend[look_b_i];
    assign pend_c_o = eff_pend[look_c_i];

    // Applied in order so later terms win: wb clear, then flush clear, then set.
    always_comb begin
        pend_d = eff_pend;
        if (fclr_en_i) begin
            pend_d = pend_d & ~reg_onehot(fclr_addr_i);
        end
        if (set_en_i) begin
            pend_d = pend_d | reg_onehot(set_addr_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage between decode and execute.
// Ports:
//   clk, reset                          - clock, synchronous active-high reset
//   in_valid/in_ready, in_rs1/rs2/rd/rd_we - decoded instruction handshake
//   read_reg_1/2, read_data_1/2         - combinational register file read port
//   wb_valid/wb_reg/wb_data             - writeback (same cycle as the RF write)
//   flush                               - squash the held output instruction
//   out_valid/out_ready, out_op1/op2/rd/rd_we - operand handshake to execute
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_rd_we,
    output logic [ADDR_W-1:0] read_reg_1,
    output logic [ADDR_W-1:0] read_reg_2,
    input  logic [WORD_W-1:0] read_data_1,
    input  logic [WORD_W-1:0] read_data_2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [WORD_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_op1,
    output logic [WORD_W-1:0] out_op2,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_rd_we
);

    logic       out_valid_q;
    logic       out_valid_d;
    out_stage_t out_q;
    out_stage_t out_d;

    logic              pend_rs1;
    logic              pend_rs2;
    logic              pend_rd;
    logic              hazard;
    logic              in_fire;
    logic              squash_writer;
    logic [WORD_W-1:0] op1_byp;
    logic [WORD_W-1:0] op2_byp;

    assign read_reg_1 = in_rs1;
    assign read_reg_2 = in_rs2;

    // A held writer that is flushed before execute takes it will never write back.
    assign squash_writer = flush && out_valid_q && out_q.rd_we && !out_ready;

    rf_scoreboard u_sb (
        .clk         (clk),
        .reset       (reset),
        .set_en_i    (in_fire && in_rd_we),
        .set_addr_i  (in_rd),
        .fclr_en_i   (squash_writer),
        .fclr_addr_i (out_q.rd),
        .clr_en_i    (wb_valid),
        .clr_addr_i  (wb_reg),
        .look_a_i    (in_rs1),
        .look_b_i    (in_rs2),
        .look_c_i    (in_rd),
        .pend_a_o    (pend_rs1),
        .pend_b_o    (pend_rs2),
        .pend_c_o    (pend_rd)
    );

    assign hazard   = in_valid && (pend_rs1 || pend_rs2 || (in_rd_we && pend_rd));
    assign in_ready = !hazard && (!out_valid_q || out_ready) && !flush && !reset;
    assign in_fire  = in_valid && in_ready;

    // The RF only sees the writeback at the next edge, so forward it here.
    assign op1_byp = (wb_valid && (wb_reg == in_rs1)) ? wb_data : read_data_1;
    assign op2_byp = (wb_valid && (wb_reg == in_rs2)) ? wb_data : read_data_2;

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_fire) begin
            out_valid_d = 1'b1;
            out_d.op1   = op1_byp;
            out_d.op2   = op2_byp;
            out_d.rd    = in_rd;
            out_d.rd_we = in_rd_we;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op1   = out_q.op1;
    assign out_op2   = out_q.op2;
    assign out_rd    = out_q.rd;
    assign out_rd_we = out_q.rd_we;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rs1, in_rs2, in_rd;
    logic              in_rd_we;
    logic [ADDR_W-1:0] read_reg_1, read_reg_2;
    logic [WORD_W-1:0] read_data_1, read_data_2;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_reg;
    logic [WORD_W-1:0] wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_op1, out_op2;
    logic [ADDR_W-1:0] out_rd;
    logic              out_rd_we;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        we;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_rd_we   (in_rd_we),
        .read_reg_1 (read_reg_1),
        .read_reg_2 (read_reg_2),
        .read_data_1(read_data_1),
        .read_data_2(read_data_2),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op1    (out_op1),
        .out_op2    (out_op2),
        .out_rd     (out_rd),
        .out_rd_we  (out_rd_we)
    );

    // Register file model: reg i holds 0x1000_00ii, except reg 25 = all ones.
    logic [31:0] rf [32];
    logic        rf_loaded = 1'b0;
    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h1000_0000 | 32'(i);
            rf[25]    <= 32'hFFFF_FFFF;
            rf_loaded <= 1'b1;
        end else if (!reset && wb_valid) begin
            rf[wb_reg] <= wb_data;
        end
    end
    assign read_data_1 = rf[read_reg_1];
    assign read_data_2 = rf[read_reg_2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] e1, input logic [31:0] e2,
                        input logic [4:0] rd, input logic we);
        exp_t e;
        e.op1 = e1; e.op2 = e2; e.rd = rd; e.we = we;
        exp_q.push_back(e);
    endtask

    // Monitor: every consumed output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got op1 %h rd %0d expected none", out_op1, out_rd);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_op1", out_op1, e.op1);
                check("out_op2", out_op2, e.op2);
                check("out_rd", 32'(out_rd), 32'(e.rd));
                check("out_rd_we", 32'(out_rd_we), 32'(e.we));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic we, input logic [31:0] e1, input logic [31:0] e2,
                         output int stalls);
        in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we;
        stalls = 0;
        @(negedge clk);
        while (!in_ready && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) check("issue_timeout", 32'(in_ready), 32'd1);
        else push(e1, e2, rd, we);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [4:0]  t3_rs1 [4];
    logic [4:0]  t3_rs2 [4];
    logic [4:0]  t3_rd  [4];
    logic [31:0] t3_e1  [4];
    logic [31:0] t3_e2  [4];

    initial begin
        int st;
        t3_rs1 = '{5'd16, 5'd17, 5'd18, 5'd19};
        t3_rs2 = '{5'd20, 5'd21, 5'd22, 5'd23};
        t3_rd  = '{5'd11, 5'd12, 5'd13, 5'd14};
        t3_e1  = '{32'h1000_0010, 32'h1000_0011, 32'h1000_0012, 32'h1000_0013};
        t3_e2  = '{32'h1000_0014, 32'h1000_0015, 32'h1000_0016, 32'h1000_0017};

        reset = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0;
        wb_valid = 1'b0; wb_reg = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1: reset state, RF read of reg 25 through op1
        @(negedge clk);
        check("t1_out_valid", 32'(out_valid), 32'd0);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        check("t1_out_op1", out_op1, 32'd0);
        check("t1_out_rd", 32'(out_rd), 32'd0);
        @(posedge clk); #1;
        issue(5'd25, 5'd0, 5'd1, 1'b0, 32'hFFFF_FFFF, 32'h1000_0000, st);
        check("t1_stall", 32'(st), 32'd0);
        idle(2);

        // 2: RAW stall released by writeback, operand bypassed
        issue(5'd1, 5'd2, 5'd3, 1'b1, 32'h1000_0001, 32'h1000_0002, st);
        in_valid = 1'b1; in_rs1 = 5'd3; in_rs2 = 5'd0; in_rd = 5'd4; in_rd_we = 1'b0;
        @(negedge clk);
        check("t2_raw_stall_a", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t2_raw_stall_b", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h0000_1234;
        @(negedge clk);
        check("t2_bypass_ready", 32'(in_ready), 32'd1);
        push(32'h0000_1234, 32'h1000_0000, 5'd4, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0; wb_valid = 1'b0;
        idle(2);

        // 3: independent back-to-back stream
        for (int k = 0; k < 4; k++) begin
            issue(t3_rs1[k], t3_rs2[k], t3_rd[k], 1'b1, t3_e1[k], t3_e2[k], st);
            check("t3_no_bubble", 32'(st), 32'd0);
        end
        idle(2);

        // 4: set wins over same-cycle writeback clear
        issue(5'd0, 5'd0, 5'd5, 1'b1, 32'h1000_0000, 32'h1000_0000, st);
        in_valid = 1'b1; in_rs1 = 5'd6; in_rs2 = 5'd7; in_rd = 5'd5; in_rd_we = 1'b1;
        wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'hAAAA_0005;
        @(negedge clk);
        check("t4_waw_cleared", 32'(in_ready), 32'd1);
        push(32'h1000_0006, 32'h1000_0007, 5'd5, 1'b1);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        in_rs1 = 5'd5; in_rs2 = 5'd0; in_rd = 5'd8; in_rd_we = 1'b0;
        @(negedge clk);
        check("t4_pend5_kept", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'hBBBB_0005;
        @(negedge clk);
        check("t4_second_wb_ready", 32'(in_ready), 32'd1);
        push(32'hBBBB_0005, 32'h1000_0000, 5'd8, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0; wb_valid = 1'b0;
        idle(2);

        // 5: flush a held writer, its pending bit is released
        out_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd7, 1'b1, 32'h1000_0001, 32'h1000_0002, st);
        flush = 1'b1;
        in_valid = 1'b1; in_rs1 = 5'd7; in_rs2 = 5'd0; in_rd = 5'd10; in_rd_we = 1'b0;
        @(negedge clk);
        check("t5_held", 32'(out_valid), 32'd1);
        check("t5_no_accept_on_flush", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        void'(exp_q.pop_front());
        @(negedge clk);
        check("t5_flushed", 32'(out_valid), 32'd0);
        check("t5_rs7_ready", 32'(in_ready), 32'd1);
        push(32'h1000_0007, 32'h1000_0000, 5'd10, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        idle(2);

        // 6: reset during a stall drops the output and the scoreboard
        out_ready = 1'b0;
        issue(5'd0, 5'd1, 5'd9, 1'b1, 32'h1000_0000, 32'h1000_0001, st);
        in_valid = 1'b1; in_rs1 = 5'd9; in_rs2 = 5'd0; in_rd = 5'd2; in_rd_we = 1'b0;
        @(negedge clk);
        check("t6_stalled", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("t6_reset_blocks", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        void'(exp_q.pop_front());
        @(negedge clk);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_out_op1", out_op1, 32'd0);
        check("t6_out_rd", 32'(out_rd), 32'd0);
        check("t6_out_rd_we", 32'(out_rd_we), 32'd0);
        check("t6_pend9_clear", 32'(in_ready), 32'd1);
        push(32'h1000_0009, 32'h1000_0000, 5'd2, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        issue(5'd11, 5'd12, 5'd13, 1'b0, 32'h1000_000B, 32'h1000_000C, st);
        check("t6_old_pend_clear", 32'(st), 32'd0);
        idle(3);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
